// File: rtl/fetch_stage_pkg.sv
// Shared pipeline package: IF/ID bubble encoding, instruction size, fetch FSM states.
package fetch_stage_pkg;

  // opcode 7'b0000000 decodes to all-zero controls downstream
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES  = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: BUBBLE_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and imem (slave).
// rdata is valid in the same cycle that ready is high.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_addr, imem_req, input  imem_rdata, imem_ready);
  modport slave  (input  imem_addr, imem_req, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear beats enable, async reset to bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  clr,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t q_q;

  // capture on enable, load bubble on clear, bubble while reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_q <= IFID_BUBBLE;
    else if (clr)  q_q <= IFID_BUBBLE;
    else if (en)   q_q <= d;
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, imem handshake FSM (BOOT/RUN/WAIT) and IF/ID register.
// Optional macro FETCH_PERF_EN adds fetch_count / flush_count performance counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic         PCSrcE,
  input  logic [31:0]  PCTargetE,
  fetch_stage_if.master imem,
  output logic [31:0]  InstrD,
  output logic [31:0]  PCD,
  output logic [31:0]  PCPlus4D,
  output logic         ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [31:0]  flush_count
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic         req;
  logic         accept;
  logic         ifid_en, ifid_clr;
  ifid_t        ifid_d, ifid_q;

  assign pc_plus4       = pc_q + INSTR_BYTES;
  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = req;

  // a word returned alongside a redirect is wrong-path and is never accepted
  assign accept = req & imem.imem_ready & ~StallF & ~PCSrcE;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // FSM next state: BOOT lasts one cycle, WAIT tracks an unanswered request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!imem.imem_ready) state_d = WAIT;
      WAIT:    if (imem.imem_ready)  state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // FSM outputs: no request while booting
  always_comb begin
    req = 1'b0;
    unique case (state_q)
      RUN, WAIT: req = 1'b1;
      default:   req = 1'b0;
    endcase
  end

  // PC next: redirect overrides stall and imem backpressure
  always_comb begin
    pc_d = pc_q;
    if (PCSrcE)      pc_d = PCTargetE;
    else if (accept) pc_d = pc_plus4;
  end

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // IF/ID control: flush wins over stall; any non-accepted, non-stalled cycle bubbles D
  always_comb begin
    ifid_d   = '{instr: imem.imem_rdata, pc: pc_q, pc_plus4: pc_plus4, valid: 1'b1};
    ifid_en  = ~StallD;
    ifid_clr = FlushD | (~StallD & ~accept);
  end

  if_id_reg u_if_id (
    .clk (clk),
    .rst (rst),
    .en  (ifid_en),
    .clr (ifid_clr),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;
  logic        flush_evt;

  // D is bubbled by a flush, or by a redirect that is not masked by StallD
  assign flush_evt = FlushD | (PCSrcE & ~StallD);

  // wrapping performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (accept)    fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (flush_evt) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes the expected IF/ID
// contents each cycle; they are popped and compared after the clock edge.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, flush_count;
`endif

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (bus.master),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // imem answers whatever address the DUT presents
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // reference model
  logic [31:0] m_pc;
  int          m_state;   // 0 BOOT, 1 RUN, 2 WAIT
  ifid_t       m_d;
  logic [31:0] m_fcnt, m_flcnt;
  ifid_t       sb[$];

  task automatic model_reset();
    m_pc = RST_PC; m_state = 0; m_d = IFID_BUBBLE;
    m_fcnt = 0; m_flcnt = 0;
    sb.delete();
  endtask

  // one clock cycle: check current outputs, drive inputs, advance model, compare D
  task automatic cyc(input bit sf, input bit sd, input bit fd, input bit ps,
                     input logic [31:0] tgt, input bit rdy);
    bit    req, acc;
    ifid_t nd, got;
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, m_state != 0});
    chk("state", 32'(dut.state_q), m_state);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    bus.imem_ready = rdy;
    req = (m_state != 0);
    acc = req & rdy & ~sf & ~ps;
    if (fd)       nd = IFID_BUBBLE;
    else if (sd)  nd = m_d;
    else if (ps)  nd = IFID_BUBBLE;
    else if (acc) nd = '{instr: mem_word(m_pc), pc: m_pc, pc_plus4: m_pc + 32'd4, valid: 1'b1};
    else          nd = IFID_BUBBLE;
    sb.push_back(nd);
    m_d = nd;
    if (acc) m_fcnt++;
    if (fd | (ps & ~sd)) m_flcnt++;
    if (ps)       m_pc = tgt;
    else if (acc) m_pc = m_pc + 32'd4;
    case (m_state)
      0:       m_state = 1;
      1:       if (!rdy) m_state = 2;
      default: if (rdy)  m_state = 1;
    endcase
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk("InstrD", InstrD, got.instr);
      chk("PCD", PCD, got.pc);
      chk("PCPlus4D", PCPlus4D, got.pc_plus4);
      chk("ValidD", {31'b0, ValidD}, {31'b0, got.valid});
    end
`ifdef FETCH_PERF_EN
    chk("fetch_count", fetch_count, m_fcnt);
    chk("flush_count", flush_count, m_flcnt);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'h0, 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_InstrD", InstrD, 32'h0);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_ValidD", {31'b0, ValidD}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    bus.imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    model_reset();

    // boot then sequential fetch from RESET_PC
    run(4);
    chk("seq_pc", PCD, 32'h108);

    // redirect while imem returns the 0x10C word
    cyc(0, 0, 0, 1, 32'h40, 1);
    chk("redir_bubble", {31'b0, ValidD}, 32'd0);
    run(2);
    chk("redir_word", PCD, 32'h44);

    // combined stall for three cycles, then resume
    repeat (3) cyc(1, 1, 0, 0, 32'h0, 1);
    run(3);

    // imem backpressure
    repeat (2) cyc(0, 0, 0, 0, 32'h0, 0);
    run(2);

    // flush wins over stall; StallD holds a valid word through backpressure
    cyc(0, 1, 1, 0, 32'h0, 1);
    run(1);
    repeat (2) cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 0, 1, 0, 32'h0, 1);

    // redirect beats StallF and missing ready; redirect under StallD holds D
    cyc(1, 0, 0, 1, 32'h200, 0);
    run(1);
    cyc(0, 1, 0, 1, 32'h300, 1);
    run(2);

    // PC wrap at top of address space
    cyc(0, 0, 0, 1, 32'hFFFF_FFF8, 1);
    run(3);
    chk("wrap_pc", bus.imem_addr, 32'h4);

    // random mix
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) == 0, $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0);
    end

    // async reset in the middle of WAIT abandons the fetch
    run(1);
    cyc(0, 0, 0, 0, 32'h0, 0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    chk_reset_outputs();
    bus.imem_ready = 1'b1;
    rst = 1'b0;
    model_reset();
    run(4);

    // async reset in the middle of a stall
    repeat (2) cyc(1, 1, 0, 0, 32'h0, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    StallF = 0; StallD = 0;
    rst = 1'b0;
    model_reset();
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port StallF  input  1  hold PC.
REQ-005 SHALL have port StallD  input  1  hold the IF/ID register.
REQ-006 SHALL have port FlushD  input  1  replace IF/ID contents with a bubble.
REQ-007 SHALL have port PCSrcE  input  1  redirect fetch to PCTargetE.
REQ-008 SHALL have port PCTargetE  input  32  branch/jal target from execute.
REQ-009 SHALL have ports imem_addr  output  32  (equals PCF), imem_req  output  1, imem_rdata  input  32, imem_ready  input  1  (rdata valid in the same cycle).
REQ-010 SHALL have ports InstrD  output  32, PCD  output  32, PCPlus4D  output  32, ValidD  output  1.

Function
REQ-011 SHALL use FSM states BOOT, RUN, WAIT: BOOT for exactly one cycle after reset release, then RUN; RUN->WAIT when imem_req=1 and imem_ready=0; WAIT->RUN when imem_ready=1.
REQ-012 SHALL drive imem_req=0 in BOOT and 1 in RUN/WAIT.
REQ-013 SHALL define fetch-accept as imem_req & imem_ready & ~StallF & ~PCSrcE.
REQ-014 SHALL update PC by priority: PCSrcE -> PCTargetE (even when StallF=1 or imem_ready=0); else fetch-accept -> PC+4 (32-bit wrap: 32'hFFFF_FFFC -> 0); else hold.
REQ-015 SHALL update IF/ID by priority: FlushD -> bubble; else StallD -> hold; else PCSrcE -> bubble; else fetch-accept -> {imem_rdata, PCF, PCF+4, ValidD=1}; else bubble.
REQ-016 SHALL define bubble as InstrD=32'h0000_0000, PCD=0, PCPlus4D=0, ValidD=0 (opcode 7'b0000000 decodes to all-zero controls).
REQ-017 SHALL give a one-cycle fetch latency: an instruction accepted at edge N appears on InstrD after edge N.
REQ-018 SHALL never lose or duplicate an instruction: accepted words enter D exactly once; a word held by StallD is presented again unchanged.
REQ-019 SHALL drop an imem word returned in the same cycle as PCSrcE (wrong path).

Reset
REQ-020 SHALL, while rst=1, asynchronously force PCF=RESET_PC, IF/ID=bubble, state=BOOT, imem_req=0.
REQ-021 SHALL, on rst asserted mid-WAIT or mid-stall, abandon the outstanding fetch with no output side effects.

Configuration
REQ-022 SHALL, with FETCH_PERF_EN defined, add outputs fetch_count  32 and flush_count  32: fetch_count +1 per fetch-accept, flush_count +1 per cycle FlushD=1 or PCSrcE=1 bubbles D, both wrapping, both reset to 0.
REQ-023 SHALL, without FETCH_PERF_EN, omit those ports and counters entirely; all other behaviour is identical.

Structure
REQ-024 SHALL place BUBBLE_INSTR (32'h0), the INSTR_BYTES constant (4) and the fetch-state enum in the shared pipeline package.
REQ-025 SHALL implement the IF/ID register as sub-module if_id_reg (enable, clear, async reset) instantiated once.

Verification
REQ-026 Reset with RESET_PC=32'h100, imem_ready=1 -> imem_req=0 for one cycle; then imem_addr=0x100,0x104,0x108; InstrD shows first word after the 2nd edge with ValidD=1.
REQ-027 PCSrcE=1, PCTargetE=0x40 while imem returns a word from 0x10C -> next imem_addr=0x40, next InstrD=bubble, word from 0x40 appears one cycle later.
REQ-028 StallF=StallD=1 for 3 cycles -> imem_addr and InstrD/PCD constant for 3 cycles; on release, fetch resumes at the next sequential PC with no gap or repeat.
REQ-029 imem_ready=0 for 2 cycles -> state WAIT, PC held, InstrD=bubble, ValidD=0; ready=1 -> word delivered once; with FETCH_PERF_EN, fetch_count increments only on accepted cycles.
REQ-030 FlushD=1 with StallD=1 simultaneously -> InstrD=bubble (flush wins); PC at 0xFFFF_FFFC with accept -> PC wraps to 0x0.
